// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
//
// Shares the single sram_ctrl command interface between two bus masters:
// port 0 (CPU) and port 1 (secondary master, e.g. video/DMA). Every side uses
// the same strobe/wait handshake. A transfer completes in the cycle where
// strobe=1 and wait=0.
//
// Arbitration is round-robin on contention. It adds zero latency: when no
// port owns the bus, the winner is picked combinationally and forwarded to
// sram_ctrl in the same cycle. If sram_ctrl stalls, the winner keeps the
// grant until its transfer completes. There is no buffering, so only one
// transaction is outstanding at a time.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   m0_* / m1_*        master ports: addr, wrdata, bytesel, wren, strobe in;
//                      wait, rddata out
//   s_*                sram_ctrl side: addr, wrdata, bytesel, wren, strobe
//                      out; wait, rddata in
//   grant_o            one-hot port currently driving sram_ctrl (00 = none)
// ---------------------------------------------------------------------------
module sram_arbiter #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wrdata,
    input  logic [DATA_W/8-1:0] m0_bytesel,
    input  logic                m0_wren,
    input  logic                m0_strobe,
    output logic                m0_wait,
    output logic [DATA_W-1:0]   m0_rddata,

    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wrdata,
    input  logic [DATA_W/8-1:0] m1_bytesel,
    input  logic                m1_wren,
    input  logic                m1_strobe,
    output logic                m1_wait,
    output logic [DATA_W-1:0]   m1_rddata,

    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wrdata,
    output logic [DATA_W/8-1:0] s_bytesel,
    output logic                s_wren,
    output logic                s_strobe,
    input  logic                s_wait,
    input  logic [DATA_W-1:0]   s_rddata,

    output logic [1:0]          grant_o
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_t;

    owner_t owner;   // port holding the grant across a stalled transfer
    logic   last;    // port that completed most recently; loses the next tie

    logic   active;  // a transfer is presented to sram_ctrl this cycle
    logic   sel_p1;  // port 1 drives sram_ctrl (port 0 otherwise)

    // Pick the port driving sram_ctrl this cycle. A locked owner keeps the bus
    // even when the other port requests. Without an owner, the arbitration is
    // resolved in the same cycle as the request.
    always_comb begin
        // NOTE: both outputs get a default before the case, so every path
        // assigns them and no latch is inferred.
        active = 1'b0;
        sel_p1 = 1'b0;
        case (owner)
            OWN_P0: begin
                sel_p1 = 1'b0;
                active = m0_strobe;      // a dropped strobe aborts the lock
            end
            OWN_P1: begin
                sel_p1 = 1'b1;
                active = m1_strobe;
            end
            default: begin
                if (m0_strobe && m1_strobe) begin
                    active = 1'b1;
                    sel_p1 = ~last;      // tie: the port that did not go last
                end else if (m0_strobe) begin
                    active = 1'b1;
                end else if (m1_strobe) begin
                    active = 1'b1;
                    sel_p1 = 1'b1;
                end
            end
        endcase
        // A reset cycle must not issue a command, even mid-transaction.
        if (reset) begin
            active = 1'b0;
        end
    end

    // When no port is active, the fields come from port 0; their values are
    // don't-care because s_strobe is low.
    assign s_addr    = sel_p1 ? m1_addr    : m0_addr;
    assign s_wrdata  = sel_p1 ? m1_wrdata  : m0_wrdata;
    assign s_bytesel = sel_p1 ? m1_bytesel : m0_bytesel;
    assign s_wren    = sel_p1 ? m1_wren    : m0_wren;
    assign s_strobe  = active;

    // The selected port sees sram_ctrl's wait. Every other port is stalled.
    assign m0_wait   = !(active && !sel_p1) || s_wait;
    assign m1_wait   = !(active &&  sel_p1) || s_wait;

    assign m0_rddata = (active && !sel_p1) ? s_rddata : '0;
    assign m1_rddata = (active &&  sel_p1) ? s_rddata : '0;

    assign grant_o   = {active && sel_p1, active && !sel_p1};

    // Completion frees the bus for a fresh arbitration in the next cycle. A
    // stall locks the grant. No activity (idle, or an aborted lock) clears
    // the owner and leaves last unchanged.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments, so every
        // register updates from the same pre-edge values.
        if (reset) begin
            owner <= OWN_NONE;
            last  <= 1'b1;               // port 0 wins the first tie
        end else if (active) begin
            if (!s_wait) begin
                owner <= OWN_NONE;
                last  <= sel_p1;
            end else begin
                owner <= sel_p1 ? OWN_P1 : OWN_P0;
            end
        end else begin
            owner <= OWN_NONE;
        end
    end

endmodule
